serial_mag_comp: RTL and testbench

SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

---
 rtl/serial_mag_comp.sv | 143 ++++++++++++++
 tb/tb_serial_mag_comp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// Serial magnitude comparator: folds MSB-first 1-bit compare results into a WIDTH-bit verdict.
// Optional result statistics are enabled by defining COMP_STATS_EN.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        bit_vld,
  input  logic        yeq,
  input  logic        yle,
  input  logic        ygt,
  output logic        busy,
  output logic        done,
  output logic        res_eq,
  output logic        res_lt,
  output logic        res_gt,
  output logic        err,
  output logic [15:0] cnt_eq,
  output logic [15:0] cnt_lt,
  output logic [15:0] cnt_gt
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic          decided_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          res_eq_reg;
  logic          res_lt_reg;
  logic          res_gt_reg;
  logic          err_reg;

  logic [2:0] pair;
  logic       one_hot;
  logic       decide_now;
  logic       last_bit;

  assign pair       = {yeq, yle, ygt};
  assign one_hot    = (pair == 3'b100) || (pair == 3'b010) || (pair == 3'b001);
  // A malformed pair counts as equal, so it can never decide the result.
  assign decide_now = one_hot && !yeq;
  assign last_bit   = (bit_cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      decided_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      res_eq_reg  <= 1'b0;
      res_lt_reg  <= 1'b0;
      res_gt_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg   <= SCAN;
            busy_reg    <= 1'b1;
            bit_cnt_reg <= '0;
            decided_reg <= 1'b0;
            err_reg     <= 1'b0;
            res_eq_reg  <= 1'b0;
            res_lt_reg  <= 1'b0;
            res_gt_reg  <= 1'b0;
          end else begin
            state_reg <= IDLE;
          end
        end
        SCAN: begin
          if (bit_vld) begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
            if (!one_hot) begin
              err_reg <= 1'b1;
            end
            if (!decided_reg && decide_now) begin
              decided_reg <= 1'b1;
              res_gt_reg  <= ygt;
              res_lt_reg  <= yle;
            end
            if (last_bit) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              if (!decided_reg && !decide_now) begin
                res_eq_reg <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign res_eq = res_eq_reg;
  assign res_lt = res_lt_reg;
  assign res_gt = res_gt_reg;
  assign err    = err_reg;

`ifdef COMP_STATS_EN
  logic [2:0]       hit;
  logic [2:0][15:0] cnt_bus;

  // Index 0/1/2 = eq/lt/gt; counted while the finished result sits in DONE.
  assign hit = {res_gt_reg, res_lt_reg, res_eq_reg};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (state_reg == DONE && hit[gi] && cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign cnt_bus[gi] = cnt_reg;
    end
  endgenerate

  assign cnt_eq = cnt_bus[0];
  assign cnt_lt = cnt_bus[1];
  assign cnt_gt = cnt_bus[2];
`else
  assign cnt_eq = '0;
  assign cnt_lt = '0;
  assign cnt_gt = '0;
`endif

endmodule

// File: tb/tb_serial_mag_comp.sv
module tb_serial_mag_comp;

    logic        clk = 1'b0;
    logic        rst_n, start, bit_vld, yeq, yle, ygt;
    logic        busy, done, res_eq, res_lt, res_gt, err;
    logic [15:0] cnt_eq, cnt_lt, cnt_gt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef COMP_STATS_EN
    localparam logic [15:0] EXP_GT     = 16'd2;
    localparam logic [15:0] EXP_EQ     = 16'd1;
    localparam logic [15:0] EXP_GT_MID = 16'd1;
`else
    localparam logic [15:0] EXP_GT     = 16'd0;
    localparam logic [15:0] EXP_EQ     = 16'd0;
    localparam logic [15:0] EXP_GT_MID = 16'd0;
`endif

    serial_mag_comp #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_vld(bit_vld),
        .yeq(yeq), .yle(yle), .ygt(ygt),
        .busy(busy), .done(done), .res_eq(res_eq), .res_lt(res_lt), .res_gt(res_gt),
        .err(err), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt), .cnt_gt(cnt_gt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s observed=%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic e, input logic l, input logic g);
        yeq = e; yle = l; ygt = g; bit_vld = 1'b1;
        tick();
        bit_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bit_vld = 1'b0; yeq = 1'b0; yle = 1'b0; ygt = 1'b0;
        tick(); tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_res", {res_eq, res_lt, res_gt}, 3'b000);
        chk("reset_err", err, 1'b0);
        chk("reset_cnt", {cnt_eq, cnt_lt, cnt_gt}, 48'd0);
        rst_n = 1'b1;
        tick();

        // A=0xA5 B=0xA4: seven equal pairs then LSB greater
        start = 1'b1; tick(); start = 1'b0;
        chk("c1_busy", busy, 1'b1);
        for (int i = 0; i < 7; i++) pair(1'b1, 1'b0, 1'b0);
        chk("c1_no_early_done", done, 1'b0);
        pair(1'b0, 1'b0, 1'b1);
        chk("c1_done", done, 1'b1);
        chk("c1_res", {res_eq, res_lt, res_gt}, 3'b001);
        chk("c1_err", err, 1'b0);
        chk("c1_busy_off", busy, 1'b0);
        tick();
        chk("c1_done_pulse", done, 1'b0);
        chk("c1_res_hold", {res_eq, res_lt, res_gt}, 3'b001);

        // A=0x3C B=0x7C: decided less at bit 6; start mid-scan must be ignored
        start = 1'b1; tick(); start = 1'b0;
        pair(1'b1, 1'b0, 1'b0);
        pair(1'b0, 1'b1, 1'b0);
        chk("c2_lt_early", res_lt, 1'b1);
        yeq = 1'b1; yle = 1'b0; ygt = 1'b0; bit_vld = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; bit_vld = 1'b0;
        for (int i = 0; i < 4; i++) pair(1'b1, 1'b0, 1'b0);
        chk("c2_no_early_done", done, 1'b0);
        pair(1'b1, 1'b0, 1'b0);
        chk("c2_done", done, 1'b1);
        chk("c2_res", {res_eq, res_lt, res_gt}, 3'b010);

        // A=B=0x55 with a stall after every pair; start accepted in DONE
        start = 1'b1; tick(); start = 1'b0;
        chk("c3_b2b_busy", busy, 1'b1);
        chk("c3_cleared", {res_eq, res_lt, res_gt}, 3'b000);
        for (int i = 0; i < 8; i++) begin
            pair(1'b1, 1'b0, 1'b0);
            if (i < 7) begin
                chk("c3_stall_done", done, 1'b0);
                yeq = 1'b0; yle = 1'b1; ygt = 1'b1;
                tick();
            end
        end
        chk("c3_done", done, 1'b1);
        chk("c3_res", {res_eq, res_lt, res_gt}, 3'b100);
        chk("c3_err", err, 1'b0);

        // Bit 3 malformed (eq+gt), then lt, then gt which must not override
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) pair(1'b1, 1'b0, 1'b0);
        pair(1'b1, 1'b0, 1'b1);
        chk("c4_err_set", err, 1'b1);
        chk("c4_bad_is_eq", {res_eq, res_lt, res_gt}, 3'b000);
        pair(1'b1, 1'b0, 1'b0);
        pair(1'b0, 1'b1, 1'b0);
        pair(1'b0, 1'b0, 1'b1);
        chk("c4_done", done, 1'b1);
        chk("c4_res", {res_eq, res_lt, res_gt}, 3'b010);
        tick();
        chk("c4_err_hold", err, 1'b1);

        // Reset after four pairs discards the comparison
        start = 1'b1; tick(); start = 1'b0;
        pair(1'b0, 1'b0, 1'b1);
        pair(1'b0, 1'b0, 1'b0);
        pair(1'b1, 1'b0, 1'b0);
        pair(1'b1, 1'b0, 1'b0);
        chk("c5_pre_busy", busy, 1'b1);
        chk("c5_pre_state", {res_gt, err}, 2'b11);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("c5_rst_busy", busy, 1'b0);
        chk("c5_rst_done", done, 1'b0);
        chk("c5_rst_res", {res_eq, res_lt, res_gt}, 3'b000);
        chk("c5_rst_err", err, 1'b0);
        chk("c5_rst_cnt", {cnt_eq, cnt_lt, cnt_gt}, 48'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("c5_no_done", done, 1'b0);
        end

        // Stats: gt, gt, eq back to back; bit_vld in IDLE and with start ignored
        pair(1'b0, 1'b1, 1'b0);
        chk("c6_idle_vld_busy", busy, 1'b0);
        yeq = 1'b0; yle = 1'b1; ygt = 1'b0; bit_vld = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; bit_vld = 1'b0;
        for (int i = 0; i < 7; i++) pair(1'b1, 1'b0, 1'b0);
        chk("c6_pair_not_consumed", done, 1'b0);
        pair(1'b0, 1'b0, 1'b1);
        chk("c6_a_res", {done, res_eq, res_lt, res_gt}, 4'b1001);
        start = 1'b1; tick(); start = 1'b0;
        chk("c6_cnt_gt_mid", cnt_gt, EXP_GT_MID);
        pair(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) pair(1'b1, 1'b0, 1'b0);
        chk("c6_b_res", {done, res_eq, res_lt, res_gt}, 4'b1001);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) pair(1'b1, 1'b0, 1'b0);
        chk("c6_c_res", {done, res_eq, res_lt, res_gt}, 4'b1100);
        tick();
        chk("c6_cnt_gt", cnt_gt, EXP_GT);
        chk("c6_cnt_eq", cnt_eq, EXP_EQ);
        chk("c6_cnt_lt", cnt_lt, 16'd0);
        chk("c6_idle_hold", {busy, res_eq}, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
